// File: rtl/truth_table_probe_pkg.sv
// Shared types and constants for the truth-table probe: FSM state encoding,
// number of input combinations swept and synchronizer depth.
package truth_table_probe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_COMBOS  = 8;
    localparam int SYNC_STAGES = 2;
    localparam int COMBO_W     = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous device output into clk.
module sync_2ff
    import truth_table_probe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_r;

    // Shift chain; the first stage may go metastable, the last is safe to use.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= {SYNC_STAGES{1'b0}};
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/truth_table_probe.sv
// Sweeps all 3-input combinations onto a logic device, captures its response
// per combination (combination 000 lands in the MSB) and compares to a code.
module truth_table_probe
    import truth_table_probe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic [2:0] probe_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match
);

    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [COMBO_W-1:0] COMBO_LAST  = COMBO_W'(NUM_COMBOS - 1);

    state_t             state_r,  state_s;
    logic [7:0]         settle_r, settle_s;
    logic [COMBO_W-1:0] combo_r,  combo_s;
    logic [7:0]         shadow_r, shadow_s;
    logic [7:0]         exp_r,    exp_s;
    logic [2:0]         probe_r,  probe_s;
    logic               busy_r,   busy_s;
    logic               done_r,   done_s;
    logic [7:0]         table_r,  table_s;
    logic               match_r,  match_s;
    logic               sync_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_out),
        .q   (sync_s)
    );

    // Next-state and next-output logic; outputs are computed one edge ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_s  = state_r;
        settle_s = settle_r;
        combo_s  = combo_r;
        shadow_s = shadow_r;
        exp_s    = exp_r;
        probe_s  = probe_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        table_s  = table_r;
        match_s  = match_r;
        case (state_r)
            ST_IDLE: begin
                probe_s = 3'b000;
                if (start) begin
                    state_s  = ST_DRIVE;
                    settle_s = 8'd0;
                    combo_s  = 3'd0;
                    exp_s    = expected;
                    busy_s   = 1'b1;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (settle_r == SETTLE_LAST) begin
                    state_s  = ST_SAMPLE;
                end else begin
                    settle_s = settle_r + 8'd1;
                end
            end
            ST_SAMPLE: begin
                shadow_s[3'd7 - combo_r] = sync_s;
                if (combo_r == COMBO_LAST) begin
                    // Final bit goes straight into the result so it is valid with done.
                    state_s = ST_DONE;
                    probe_s = 3'b000;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    table_s = shadow_s;
                    match_s = (shadow_s == exp_r);
                end else begin
                    state_s  = ST_DRIVE;
                    combo_s  = combo_r + 3'd1;
                    settle_s = 8'd0;
                    probe_s  = combo_r + 3'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                probe_s = 3'b000;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                probe_s = 3'b000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            settle_r <= 8'd0;
            combo_r  <= 3'd0;
            shadow_r <= 8'h00;
            exp_r    <= 8'h00;
            probe_r  <= 3'b000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            table_r  <= 8'h00;
            match_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            settle_r <= settle_s;
            combo_r  <= combo_s;
            shadow_r <= shadow_s;
            exp_r    <= exp_s;
            probe_r  <= probe_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            table_r  <= table_s;
            match_r  <= match_s;
        end
    end

    assign probe_in  = probe_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign table_out = table_r;
    assign match     = match_r;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench: table of device codes swept on a default instance, plus
// re-pulse, mid-sweep reset and a short-settle instance checked cycle by cycle.
module tb_truth_table_probe;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] expected_a, expected_b;
    logic [7:0] dev_a, dev_b;
    logic       dut_out_a, dut_out_b;
    logic [2:0] probe_a, probe_b;
    logic       busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [7:0] table_a, table_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Behavioural 3-input devices: response to combination c is code bit 7-c.
    assign dut_out_a = dev_a[3'd7 - probe_a];
    assign dut_out_b = dev_b[3'd7 - probe_b];

    truth_table_probe #(.SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(expected_a),
        .dut_out(dut_out_a), .probe_in(probe_a), .busy(busy_a), .done(done_a),
        .table_out(table_a), .match(match_a)
    );

    truth_table_probe #(.SETTLE_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(expected_b),
        .dut_out(dut_out_b), .probe_in(probe_b), .busy(busy_b), .done(done_b),
        .table_out(table_b), .match(match_b)
    );

    typedef struct {
        logic [7:0] code;
        logic [7:0] exp_v;
        logic [7:0] want_table;
        logic       want_match;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Starts a sweep on instance A (accepted at the next edge, cycle 0) and
    // watches len cycles; start is re-driven at cycles p1..p3 if nonzero.
    task automatic sweep_a(input logic [7:0] code, input logic [7:0] exp_v,
                           input int p1, input int p2, input int p3, input int len,
                           output int first_k, output int second_k, output int n_done);
        dev_a = code;
        first_k = 0;
        second_k = 0;
        n_done = 0;
        @(negedge clk);
        start_a = 1'b1;
        expected_a = exp_v;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (done_a) begin
                n_done++;
                if (n_done == 1) first_k = k;
                else if (n_done == 2) second_k = k;
            end
            start_a = (k == p1 || k == p2 || k == p3) ? 1'b1 : 1'b0;
            if (k == 3) expected_a = ~exp_v;
        end
        start_a = 1'b0;
    endtask

    vec_t vecs[6];
    int   fk, sk, nd;
    logic [7:0] prev_table;

    initial begin
        vecs[0] = '{8'hB3, 8'hB3, 8'hB3, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[3] = '{8'hB3, 8'hB2, 8'hB3, 1'b0};
        vecs[4] = '{8'h5A, 8'h5A, 8'h5A, 1'b1};
        vecs[5] = '{8'h01, 8'h80, 8'h01, 1'b0};

        rst = 1'b1;
        start_a = 1'b1;
        start_b = 1'b0;
        expected_a = 8'hFF;
        expected_b = 8'h00;
        dev_a = 8'hFF;
        dev_b = 8'hB3;
        repeat (3) @(negedge clk);
        check("reset probe_in", 32'(probe_a), 32'h0);
        check("reset busy", 32'(busy_a), 32'h0);
        check("reset done", 32'(done_a), 32'h0);
        check("reset table_out", 32'(table_a), 32'h0);
        check("reset match", 32'(match_a), 32'h0);
        rst = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        check("rst priority over start", 32'(busy_a), 32'h0);

        for (int i = 0; i < 6; i++) begin
            sweep_a(vecs[i].code, vecs[i].exp_v, 0, 0, 0, 45, fk, sk, nd);
            check($sformatf("vec%0d done cycle", i), 32'(fk), 32'd41);
            check($sformatf("vec%0d done count", i), 32'(nd), 32'd1);
            check($sformatf("vec%0d table_out", i), 32'(table_a), 32'(vecs[i].want_table));
            check($sformatf("vec%0d match", i), 32'(match_a), 32'(vecs[i].want_match));
            check($sformatf("vec%0d busy idle", i), 32'(busy_a), 32'h0);
        end

        // Re-pulses at 5 and 41 are ignored; the pulse at 42 starts a new sweep.
        sweep_a(8'hB3, 8'hB3, 5, 41, 42, 90, fk, sk, nd);
        check("repulse first done", 32'(fk), 32'd41);
        check("repulse second done", 32'(sk), 32'd83);
        check("repulse done count", 32'(nd), 32'd2);

        // Mid-sweep reset at cycle 20.
        prev_table = table_a;
        dev_a = 8'h3C;
        @(negedge clk);
        start_a = 1'b1;
        expected_a = 8'h3C;
        nd = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (done_a) nd++;
            if (k == 10) check("table held mid-sweep", 32'(table_a), 32'(prev_table));
            if (k == 19) check("busy mid-sweep", 32'(busy_a), 32'h1);
            if (k == 20) rst = 1'b1;
        end
        check("abort probe_in", 32'(probe_a), 32'h0);
        check("abort busy", 32'(busy_a), 32'h0);
        check("abort done", 32'(done_a), 32'h0);
        check("abort table_out", 32'(table_a), 32'h0);
        check("abort match", 32'(match_a), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        check("abort no done", 32'(nd), 32'd0);
        sweep_a(8'h3C, 8'h3C, 0, 0, 0, 45, fk, sk, nd);
        check("post-abort done cycle", 32'(fk), 32'd41);
        check("post-abort table_out", 32'(table_a), 32'h3C);
        check("post-abort match", 32'(match_a), 32'h1);

        // Short-settle instance: each combination held 3 cycles, done at 25.
        @(negedge clk);
        start_b = 1'b1;
        expected_b = 8'hB3;
        fk = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (done_b && fk == 0) fk = k;
            if (k <= 24) check($sformatf("s2 probe k%0d", k), 32'(probe_b), 32'((k - 1) / 3));
            if (k == 25) check("s2 probe after sweep", 32'(probe_b), 32'h0);
        end
        check("s2 done cycle", 32'(fk), 32'd25);
        check("s2 table_out", 32'(table_b), 32'hB3);
        check("s2 match", 32'(match_b), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
